// File: rtl/axi_led_pwm_if.sv
// AXI4-Lite slave bus bundle for the LED PWM block (32-bit data, ADDR_W-bit byte address).
// Signal names follow the AXI port names so the block drops straight into a Xilinx-style wrapper.
interface axi_led_pwm_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_led_pwm.sv
// AXI4-Lite controlled multi-channel LED PWM with prescaler and optional blink; LED is registered (1 cycle).
// One outstanding transaction per direction: AW/W and AR stall while the matching B or R response waits for READY.
module axi_led_pwm #(
    parameter int NUM_LEDS           = 4,
    parameter int PWM_WIDTH          = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    axi_led_pwm_if.slave        s_axi,
    output logic [NUM_LEDS-1:0] LED
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register word index; the two byte-offset bits are dropped.
    function automatic logic [31:0] word_idx(input logic [AW-1:0] a);
        word_idx = 32'(a >> 2);
    endfunction

    function automatic logic [31:0] reg_rd(
        input  logic [31:0]                         idx,
        input  logic [1:0]                          ctrl,
        input  logic [NUM_LEDS-1:0]                 mask,
        input  logic [15:0]                         presc,
        input  logic [31:0]                         stat,
        input  logic [NUM_LEDS-1:0][PWM_WIDTH-1:0]  duty,
        output logic                                hit
    );
        reg_rd = '0;
        hit    = 1'b1;
        case (idx)
            32'd0: reg_rd[1:0]          = ctrl;
            32'd1: reg_rd[NUM_LEDS-1:0] = mask;
            32'd2: reg_rd[15:0]         = presc;
            32'd3: reg_rd               = stat;
            default: begin
                hit = 1'b0;
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (idx == 32'(4 + i)) begin
                        reg_rd[PWM_WIDTH-1:0] = duty[i];
                        hit = 1'b1;
                    end
                end
            end
        endcase
    endfunction

    logic                               aw_rdy_q, aw_rdy_d;
    logic                               bvalid_q, bvalid_d;
    logic [1:0]                         bresp_q, bresp_d;
    logic                               ar_rdy_q, ar_rdy_d;
    logic                               rvalid_q, rvalid_d;
    logic [1:0]                         rresp_q, rresp_d;
    logic [31:0]                        rdata_q, rdata_d;
    logic [1:0]                         ctrl_q, ctrl_d;
    logic [NUM_LEDS-1:0]                mask_q, mask_d;
    logic [15:0]                        prescale_q, prescale_d;
    logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] duty_q, duty_d;
    logic [15:0]                        presc_cnt_q, presc_cnt_d;
    logic [PWM_WIDTH-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic                               phase_q, phase_d;
    logic [NUM_LEDS-1:0]                led_q, led_d;

    logic [31:0] status;
    logic [31:0] wr_idx, wr_old, wr_new;
    logic        wr_hit, wr_err, wr_fire, wr_ok, presc_wr;
    logic [31:0] rd_idx, rd_val;
    logic        rd_hit, rd_fire;
    logic        en, blink, tick, wrap;
    logic        unused_sigs;

    assign unused_sigs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_new};

    always_comb begin
        status                  = '0;
        status[PWM_WIDTH-1:0]   = pwm_cnt_q;
        status[16]              = phase_q;
        status[31:24]           = 8'(NUM_LEDS);
    end

    // Write path: read-modify-write through WSTRB so partial writes keep untouched bytes.
    always_comb begin
        wr_idx  = word_idx(s_axi.S_AXI_AWADDR);
        wr_old  = reg_rd(wr_idx, ctrl_q, mask_q, prescale_q, status, duty_q, wr_hit);
        wr_err  = ~wr_hit | (wr_idx == 32'd3);
        wr_new  = wr_old;
        for (int b = 0; b < 4; b++) begin
            if (s_axi.S_AXI_WSTRB[b]) wr_new[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
        end
        wr_fire  = aw_rdy_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
        wr_ok    = wr_fire & ~wr_err;
        presc_wr = wr_ok & (wr_idx == 32'd2);
        aw_rdy_d = ~aw_rdy_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;

        ctrl_d     = ctrl_q;
        mask_d     = mask_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        if (wr_ok) begin
            case (wr_idx)
                32'd0: ctrl_d     = wr_new[1:0];
                32'd1: mask_d     = wr_new[NUM_LEDS-1:0];
                32'd2: prescale_d = wr_new[15:0];
                default: begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (wr_idx == 32'(4 + i)) duty_d[i] = wr_new[PWM_WIDTH-1:0];
                    end
                end
            endcase
        end

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path samples the pre-write register state, so a same-edge write is not visible.
    always_comb begin
        rd_idx   = word_idx(s_axi.S_AXI_ARADDR);
        rd_val   = reg_rd(rd_idx, ctrl_q, mask_q, prescale_q, status, duty_q, rd_hit);
        rd_fire  = ar_rdy_q & s_axi.S_AXI_ARVALID;
        ar_rdy_d = ~ar_rdy_q & s_axi.S_AXI_ARVALID & ~rvalid_q;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        en    = ctrl_q[0];
        blink = ctrl_q[1];
        tick  = en & (presc_cnt_q == prescale_q);
        wrap  = tick & (pwm_cnt_q == PWM_MAX);

        presc_cnt_d = (~en | presc_wr | tick) ? 16'd0 : presc_cnt_q + 16'd1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        phase_d     = ~blink ? 1'b0 : (wrap ? ~phase_q : phase_q);

        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = en & mask_q[i]
                     & ((pwm_cnt_q < duty_q[i]) | (duty_q[i] == PWM_MAX))
                     & (~blink | phase_q);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_rdy_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            ar_rdy_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            mask_q      <= '0;
            prescale_q  <= '0;
            duty_q      <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            phase_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            aw_rdy_q    <= aw_rdy_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            ar_rdy_q    <= ar_rdy_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            mask_q      <= mask_d;
            prescale_q  <= prescale_d;
            duty_q      <= duty_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = aw_rdy_q;
    assign s_axi.S_AXI_WREADY  = aw_rdy_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = ar_rdy_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign LED                 = led_q;
endmodule
